// File: rtl/draw_pkg.sv
// Shared draw-engine constants and types for the tile-map row prefetcher.
package draw_pkg;
  localparam int COOR_X     = 254;
  localparam int COOR_Y     = 32;
  localparam int TILE_WIDTH = 32;
  localparam int MAP_TILES  = 11;
  localparam int ID_WIDTH   = 8;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int H_ACTIVE   = 640;
  localparam int MAP_PIX    = MAP_TILES * TILE_WIDTH;
  localparam int TILE_SH    = $clog2(TILE_WIDTH);
  localparam logic [3:0] LAST_COL = 4'(MAP_TILES - 1);

  typedef logic [ID_WIDTH-1:0] tile_id_t;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, READY} fetch_state_t;
endpackage

// File: rtl/row_line_buffer.sv
// Double-buffered map row: back half filled by the fetcher, front half read by the pixel stage.
module row_line_buffer
  import draw_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [3:0]          wr_col_i,
  input  logic [ID_WIDTH-1:0] wr_data_i,
  input  logic                swap_i,
  input  logic [3:0]          rd_col_i,
  output logic [ID_WIDTH-1:0] rd_data_o
);
  tile_id_t back_q  [MAP_TILES];
  tile_id_t front_q [MAP_TILES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAP_TILES; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      if (wr_en_i) back_q[wr_col_i] <= wr_data_i;
      if (swap_i)  front_q <= back_q;
    end
  end

  assign rd_data_o = front_q[rd_col_i];
endmodule

// File: rtl/map_row_prefetch.sv
// Fetches the next scanline's map row during hblank and serves tile IDs under DrawX.
module map_row_prefetch
  import draw_pkg::*;
#(
  parameter int MAP_LATENCY = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic                map_req,
  output logic [6:0]          map_addr,
  input  logic                map_gnt,
  input  logic [ID_WIDTH-1:0] map_rdata,
  output logic [ID_WIDTH-1:0] tile_id,
  output logic                tile_valid,
  output logic                busy,
  output logic                overrun
);
  fetch_state_t state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d, front_row_q, front_row_d;
  logic       front_ok_q, front_ok_d, overrun_q, overrun_d;
  logic       buf_swap, flush, push, wr_en;
  logic [MAP_LATENCY-1:0]      vld_pipe_q;
  logic [MAP_LATENCY-1:0][3:0] tag_pipe_q;
  logic [9:0] next_y;
  logic [3:0] next_row, rd_col;
  logic       next_in_map, hit_fetch, swap, in_x, in_y;
  tile_id_t   rd_data, tile_id_q;
  logic       tile_valid_q;

  assign next_y      = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
  assign next_in_map = (next_y >= 10'(COOR_Y)) && (next_y < 10'(COOR_Y + MAP_PIX));
  assign next_row    = 4'((next_y - 10'(COOR_Y)) >> TILE_SH);
  assign hit_fetch   = (DrawX == 10'(H_ACTIVE));
  assign swap        = (DrawX == 10'(H_TOTAL - 1));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    front_row_d = front_row_q;
    front_ok_d  = front_ok_q;
    overrun_d   = overrun_q;
    buf_swap    = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap) begin
          if (!next_in_map) front_ok_d = 1'b0;
        end else if (hit_fetch && next_in_map &&
                     (!front_ok_q || next_row != front_row_q)) begin
          state_d = REQ;
          row_d   = next_row;
          col_d   = '0;
        end
      end
      REQ, DRAIN: begin
        if (swap) begin
          // Deadline missed: drop in-flight data and blank the front row.
          overrun_d  = 1'b1;
          front_ok_d = 1'b0;
          flush      = 1'b1;
          state_d    = IDLE;
        end else if (state_q == REQ) begin
          if (map_gnt) begin
            col_d = col_q + 4'd1;
            if (col_q == LAST_COL) state_d = DRAIN;
          end
        end else if (!(|vld_pipe_q)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (swap) begin
          buf_swap    = 1'b1;
          front_row_d = row_q;
          front_ok_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push  = (state_q == REQ) && map_gnt && !swap;
  assign wr_en = vld_pipe_q[MAP_LATENCY-1] && !swap;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      front_row_q <= '0;
      front_ok_q  <= 1'b0;
      overrun_q   <= 1'b0;
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      front_row_q <= front_row_d;
      front_ok_q  <= front_ok_d;
      overrun_q   <= overrun_d;
      tag_pipe_q[0] <= col_q;
      for (int i = 1; i < MAP_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
      if (flush) vld_pipe_q <= '0;
      else begin
        vld_pipe_q[0] <= push;
        for (int i = 1; i < MAP_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  row_line_buffer u_buf (
    .clk       (Clk),
    .rst       (Reset),
    .wr_en_i   (wr_en),
    .wr_col_i  (tag_pipe_q[MAP_LATENCY-1]),
    .wr_data_i (map_rdata),
    .swap_i    (buf_swap),
    .rd_col_i  (rd_col),
    .rd_data_o (rd_data)
  );

  assign rd_col = 4'((DrawX - 10'(COOR_X)) >> TILE_SH);
  assign in_x   = (DrawX >= 10'(COOR_X)) && (DrawX < 10'(COOR_X + MAP_PIX));
  assign in_y   = (DrawY >= 10'(COOR_Y)) && (DrawY < 10'(COOR_Y + MAP_PIX));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tile_valid_q <= 1'b0;
      tile_id_q    <= '0;
    end else begin
      tile_valid_q <= front_ok_q && in_x && in_y;
      tile_id_q    <= (front_ok_q && in_x && in_y) ? rd_data : '0;
    end
  end

  assign map_req    = (state_q == REQ);
  assign map_addr   = map_req ? 7'(row_q) * 7'(MAP_TILES) + 7'(col_q) : '0;
  assign tile_id    = tile_id_q;
  assign tile_valid = tile_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_map_row_prefetch.sv
// Randomized bench for map_row_prefetch against a line-level behavioural model.
module tb_map_row_prefetch;
  import draw_pkg::*;
  localparam int L = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       map_req, map_gnt, tile_valid, busy, overrun;
  logic [6:0] map_addr;
  logic [7:0] map_rdata, tile_id;

  always #5 Clk = ~Clk;

  map_row_prefetch #(.MAP_LATENCY(L)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .map_req(map_req), .map_addr(map_addr), .map_gnt(map_gnt), .map_rdata(map_rdata),
    .tile_id(tile_id), .tile_valid(tile_valid), .busy(busy), .overrun(overrun)
  );

  int nvec = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (DrawX=%0d DrawY=%0d t=%0t)", nm, act, exp, DrawX, DrawY, $time);
    end
  endtask

  // Map RAM contents: row*16 + col.
  function automatic logic [7:0] memv(input int a);
    return 8'((a / MAP_TILES) * 16 + (a % MAP_TILES));
  endfunction
  function automatic int nexty(input int y);
    return (y == V_TOTAL - 1) ? 0 : y + 1;
  endfunction
  function automatic bit in_map(input int y);
    return (y >= COOR_Y) && (y < COOR_Y + MAP_PIX);
  endfunction

  // Behavioural model: one fetch record per line, front row as a plain array.
  bit         m_fetch, m_fok, m_ovr, e_tv, prev_req;
  int         m_row, m_gr, m_rlast, m_frow, mcyc = 0, nfetch = 0;
  logic [7:0] m_front [MAP_TILES];
  logic [7:0] e_tid;

  always @(negedge Clk) begin
    int x, y;
    bit exp_req;
    if (Reset) begin
      chk("rst_map_req", map_req, 0);   chk("rst_map_addr", map_addr, 0);
      chk("rst_tile_id", tile_id, 0);   chk("rst_tile_valid", tile_valid, 0);
      chk("rst_busy", busy, 0);         chk("rst_overrun", overrun, 0);
      m_fetch = 0; m_fok = 0; m_ovr = 0; e_tv = 0; e_tid = '0; prev_req = 0;
    end else begin
      exp_req = m_fetch && (m_gr < MAP_TILES);
      chk("map_req", map_req, exp_req);
      chk("map_addr", map_addr, exp_req ? m_row * MAP_TILES + m_gr : 0);
      chk("busy", busy, m_fetch);
      chk("overrun", overrun, m_ovr);
      chk("tile_valid", tile_valid, e_tv);
      chk("tile_id", tile_id, e_tid);
      if (map_req && !prev_req) nfetch++;
      prev_req = map_req;
      x = int'(DrawX); y = int'(DrawY);
      e_tv  = m_fok && x >= COOR_X && x < COOR_X + MAP_PIX && in_map(y);
      e_tid = e_tv ? m_front[(x - COOR_X) / TILE_WIDTH] : 8'h00;
      if (exp_req && map_gnt && x != H_TOTAL - 1) begin
        m_gr++;
        if (m_gr == MAP_TILES) m_rlast = mcyc + L;
      end
      if (x == H_TOTAL - 1) begin
        if (m_fetch) begin
          // Last word must land and the drain must settle before the swap cycle.
          if (m_gr == MAP_TILES && mcyc >= m_rlast + 2) begin
            m_fok = 1; m_frow = m_row;
            for (int c = 0; c < MAP_TILES; c++) m_front[c] = memv(m_row * MAP_TILES + c);
          end else begin
            m_ovr = 1; m_fok = 0;
          end
          m_fetch = 0;
        end else if (!in_map(nexty(y))) m_fok = 0;
      end else if (x == H_ACTIVE && !m_fetch && in_map(nexty(y)) &&
                   (!m_fok || (nexty(y) - COOR_Y) / TILE_WIDTH != m_frow)) begin
        m_fetch = 1; m_row = (nexty(y) - COOR_Y) / TILE_WIDTH; m_gr = 0;
      end
    end
    mcyc++;
  end

  // Stimulus: VGA coordinates, grant pattern and a latency-L map RAM.
  int         gnt_mode = 0, cyc = 0;
  bit         sched_v [8];
  int         sched_a [8];
  bit         lit_on = 0;
  string      lit_nm;
  logic [8:0] lit_exp;

  task automatic step(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y);
    case (gnt_mode)
      0:       map_gnt = 1'b1;
      1:       map_gnt = ($urandom_range(0, 3) == 0);
      default: map_gnt = 1'b0;
    endcase
    if (sched_v[cyc % 8]) begin
      map_rdata = memv(sched_a[cyc % 8]);
      sched_v[cyc % 8] = 0;
    end else map_rdata = 8'($urandom);
    @(negedge Clk);
    if (lit_on) begin
      lit_on = 0;
      chk(lit_nm, {tile_valid, tile_id}, lit_exp);
    end
    if (map_req && map_gnt) begin
      sched_v[(cyc + L) % 8] = 1;
      sched_a[(cyc + L) % 8] = int'(map_addr);
    end
    @(posedge Clk); #1;
    cyc++;
  endtask

  task automatic lit(input string nm, input bit v, input logic [7:0] id, input int x, input int y);
    step(x, y);
    lit_on = 1; lit_nm = nm; lit_exp = {v, id};
    step(x + 1, y);
  endtask

  task automatic drive_line(input int y, input bit full, input int nsamp);
    for (int k = 0; k < nsamp; k++) step($urandom_range(240, 620), y);
    if (full) for (int x = 640; x < H_TOTAL; x++) step(x, y);
    else begin
      for (int x = 636; x <= 660; x++) step(x, y);
      for (int x = 797; x < H_TOTAL; x++) step(x, y);
    end
  endtask

  task automatic scan_active(input int y);
    for (int x = COOR_X; x < COOR_X + MAP_PIX; x++) step(x, y);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) sched_v[i] = 0;
    Reset = 1'b1; DrawX = '0; DrawY = '0; map_gnt = 1'b0; map_rdata = '0;
    repeat (3) step(0, 0);
    Reset = 1'b0;

    // Full frame, grant always high, compressed lines.
    gnt_mode = 0;
    for (int y = 0; y < V_TOTAL; y++) begin
      if (y == 32) lit("row0_col3", 1, 8'h03, COOR_X + 3 * 32, 32);
      if (y == 100) begin
        lit("row2_col10", 1, 8'h2A, COOR_X + 10 * 32 + 31, 100);
        lit("edge_253", 0, 8'h00, 253, 100);
        lit("edge_606", 0, 8'h00, 606, 100);
      end
      drive_line(y, 0, 4);
    end
    chk("fetches_per_frame", nfetch, 11);

    // Wrap and grant stalls with random 25% duty.
    nfetch = 0;
    gnt_mode = 1;
    drive_line(524, 0, 4);
    drive_line(0, 0, 4);
    chk("no_fetch_524_0", nfetch, 0);
    drive_line(31, 1, 4);
    chk("wrap_fetch_line31", nfetch, 1);
    scan_active(32);
    drive_line(32, 1, 0);
    drive_line(63, 1, 4);
    scan_active(64);
    drive_line(64, 1, 4);
    drive_line(95, 1, 4);
    scan_active(96);

    // Starvation at line 31.
    gnt_mode = 2;
    drive_line(31, 1, 4);
    chk("overrun_set", overrun, 1);
    gnt_mode = 0;
    lit("starve_line32_invalid", 0, 8'h00, COOR_X + 3 * 32, 32);
    drive_line(32, 1, 4);
    lit("refetch_line33", 1, 8'h03, COOR_X + 3 * 32, 33);
    drive_line(33, 0, 4);

    // Reset in the middle of a fetch (col 5 pending).
    drive_line(63, 0, 0);
    for (int x = 636; x <= 645; x++) step(x, 63);
    Reset = 1'b1;
    step(646, 63);
    step(647, 63);
    Reset = 1'b0;
    chk("overrun_cleared", overrun, 0);
    for (int x = 648; x < H_TOTAL; x++) step(x, 63);
    drive_line(64, 1, 4);
    lit("after_reset_row1", 1, 8'h15, COOR_X + 5 * 32 + 7, 65);
    drive_line(65, 0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/map_row_prefetch.md
# map_row_prefetch

Scheduler that feeds the tile-map lookup of the draw engine. During horizontal blanking it fetches the tile IDs of the map row the next scanline will cross from the shared map RAM into a back line buffer. It swaps that buffer to the front at end of line and serves the tile ID under the current DrawX to the sprite/pixel stage. Map RAM access is shared with game logic through a request/grant handshake.

## Interface
- COOR_X, 254, screen X of map area left edge
- COOR_Y, 32, screen Y of map area top edge
- TILE_WIDTH, 32, tile edge in pixels (power of two)
- MAP_TILES, 11, tiles per row and per column
- ID_WIDTH, 8, tile ID width
- MAP_LATENCY, 2, cycles from granted read to valid map_rdata (≥1)
- H_TOTAL, 800 / V_TOTAL, 525 / H_ACTIVE, 640, VGA timing
- Clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high
- DrawX, DrawY  in  10 each  current pixel coordinate from VGA controller
- map_req  out  1  read request to map RAM arbiter
- map_addr  out  7  row*MAP_TILES + col; stable while map_req high and not granted
- map_gnt  in  1  request accepted this cycle
- map_rdata  in  ID_WIDTH  read data, MAP_LATENCY cycles after grant
- tile_id  out  ID_WIDTH  tile ID under previous cycle's DrawX
- tile_valid  out  1  tile_id meaningful
- busy  out  1  fetch in progress
- overrun  out  1  sticky: fetch missed its swap deadline

## Operation
- next_y = (DrawY == V_TOTAL-1) ? 0 : DrawY+1; next line in map iff COOR_Y ≤ next_y < COOR_Y+MAP_TILES*TILE_WIDTH; next_row = (next_y−COOR_Y)/TILE_WIDTH, 4 bits.
- Front buffer holds front_row (4 bits) and front_ok. Back buffer: MAP_TILES × ID_WIDTH.
- FSM states: IDLE, REQ, DRAIN, READY.
- IDLE → REQ at the DrawX == H_ACTIVE cycle iff next line in map and (!front_ok or next_row ≠ front_row). Otherwise no fetch; the row is reused over its TILE_WIDTH lines.
- REQ: map_req=1, map_addr = next_row*MAP_TILES + col, col from 0. On map_gnt, col++ and push {valid, col} into a MAP_LATENCY-deep shift register. After grant of col MAP_TILES−1 → DRAIN.
- Each response with a valid tag writes map_rdata into back[tag]. DRAIN → READY when shift register empty.
- Swap at the DrawX == H_TOTAL−1 cycle:
  - READY: front ← back, front_row ← fetched row, front_ok=1, → IDLE.
  - REQ/DRAIN: overrun ← 1, front_ok ← 0, in-flight tags flushed (late data dropped), map_req drops next cycle, → IDLE.
  - IDLE with next line outside map: front_ok ← 0.
- Output: posX = DrawX − COOR_X (10-bit wrap), col = posX/TILE_WIDTH. tile_valid = front_ok and DrawX in [COOR_X, COOR_X+MAP_TILES*TILE_WIDTH) and DrawY in map area. tile_id = front[col] when valid, else 0.
- busy = state ∈ {REQ, DRAIN, READY}.

## Timing
- Reset values: map_req 0, map_addr 0, tile_id 0, tile_valid 0, busy 0, overrun 0. State IDLE, front_ok 0, tags cleared.
- tile_id/tile_valid are registered, latency 1 cycle from DrawX/DrawY.
- Best-case fetch with map_gnt tied high: MAP_TILES + MAP_LATENCY + 1 cycles = 14 cycles, within the 160-cycle blank.
- map_gnt ignored when map_req low. map_req may stay high for any number of ungranted cycles, with map_addr unchanged.
- A swap and a response in the same cycle: the swap wins and the response is dropped.
- overrun clears only on Reset.

## Structure
- Package draw_pkg: TILE_WIDTH, MAP_TILES, screen/VGA constants, tile_id_t, fetch_state_t enum.
- One sub-module, row_line_buffer: double-buffered MAP_TILES×ID_WIDTH registers with write port, swap strobe and combinational read by col.

## Test plan
- Reset mid-REQ (col=5): all outputs 0 next cycle. After release, no map_req until the next DrawX=640 with a qualifying line.
- Frame scan, map_gnt=1, map rows hold value row*16+col: at DrawY=32, DrawX=254+3*32 → tile_id 0x03 next cycle. At DrawY=100, DrawX=254+10*32+31 → 0x2A.
- Row reuse: exactly 11 fetches per frame (one per row). No map_req during hblank of lines 32–62 except line 31's.
- Grant stalls: map_gnt random 25% duty, MAP_LATENCY=3. All 11 addresses are issued in order. Buffer contents are correct, and map_addr is held stable while stalled.
- Starvation: map_gnt=0 through line 31 blank → overrun=1 at DrawX=799. tile_valid=0 across line 32. Line 33 refetches and shows valid data.
- Edges: DrawX=253 and 606 → tile_valid 0. DrawY=524→0 wrap: no fetch at line 524. Fetch occurs on line 31.
